// File: rtl/rr_task_scheduler.sv
// -----------------------------------------------------------------------------
// rr_task_scheduler
//
// Round-robin, time-sliced task scheduler running off the 1 Hz tick strobe.
// One ready task at a time is granted a slice of `quantum` ticks (DEF_QUANTUM
// when quantum is 0). The running task is preempted when its slice expires,
// when it yields, or when its ready request drops. The next owner is the first
// ready task found after the last grant, wrapping around, with the last grant
// itself considered last. This lets a sole ready task be re-granted to itself.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active low
//   tick       in   one-cycle 1 Hz strobe
//   ready      in   [NUM_TASKS] per-task ready level
//   yield      in   one-cycle pulse, running task gives up its slice
//   quantum    in   [4] slice length in ticks, 0 selects DEF_QUANTUM
//   task_no    out  [4] running task id, 4'hF when idle
//   timer_left out  [4] ticks left in the current slice, 0 when idle
//   busy       out  high while a task is running
//   ctx_switch out  one-cycle pulse on every grant
// -----------------------------------------------------------------------------
module rr_task_scheduler #(
    parameter int NUM_TASKS   = 4,
    parameter int DEF_QUANTUM = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [NUM_TASKS-1:0] ready,
    input  logic                 yield,
    input  logic [3:0]           quantum,
    output logic [3:0]           task_no,
    output logic [3:0]           timer_left,
    output logic                 busy,
    output logic                 ctx_switch
);

    localparam logic [3:0] NO_TASK = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] last_grant;

    logic [15:0] rdy16;
    logic        any_ready;
    logic [3:0]  sel_id;
    logic        sel_found;
    logic [3:0]  load_val;
    logic        end_slice;

    // Zero-extend so the running task id can index without width games.
    assign rdy16     = 16'(ready);
    assign any_ready = |ready;
    assign load_val  = (quantum != 4'd0) ? quantum : 4'(DEF_QUANTUM);

    // Search last_grant+1 .. last_grant+NUM_TASKS (mod NUM_TASKS); the final
    // candidate is last_grant itself. Index math stays below NUM_TASKS, so
    // it never overflows 4 bits.
    always_comb begin
        logic [3:0] idx;
        sel_id    = 4'd0;
        sel_found = 1'b0;
        idx       = 4'd0;
        for (int i = 1; i <= NUM_TASKS; i++) begin
            if (last_grant >= 4'(NUM_TASKS - i))
                idx = last_grant - 4'(NUM_TASKS - i);
            else
                idx = last_grant + 4'(i);
            if (!sel_found && rdy16[idx]) begin
                sel_found = 1'b1;
                sel_id    = idx;
            end
        end
    end

    // Any mix of expiry, yield and lost ready collapses into one switch.
    assign end_slice = (tick && (timer_left == 4'd1)) || yield || !rdy16[task_no];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            task_no    <= NO_TASK;
            timer_left <= 4'd0;
            busy       <= 1'b0;
            ctx_switch <= 1'b0;
            last_grant <= 4'(NUM_TASKS - 1);
        end else begin
            ctx_switch <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_ready && sel_found) begin
                        state      <= RUN;
                        task_no    <= sel_id;
                        timer_left <= load_val;
                        busy       <= 1'b1;
                        ctx_switch <= 1'b1;
                        last_grant <= sel_id;
                    end
                end
                RUN: begin
                    if (end_slice) begin
                        if (any_ready && sel_found) begin
                            task_no    <= sel_id;
                            timer_left <= load_val;
                            busy       <= 1'b1;
                            ctx_switch <= 1'b1;
                            last_grant <= sel_id;
                        end else begin
                            state      <= IDLE;
                            task_no    <= NO_TASK;
                            timer_left <= 4'd0;
                            busy       <= 1'b0;
                        end
                    end else if (tick) begin
                        // end_slice already covers timer_left==1, so this
                        // never drops below 1.
                        timer_left <= timer_left - 4'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    task_no    <= NO_TASK;
                    timer_left <= 4'd0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
